// File: rtl/ps2_pkg.sv
// Shared constants, decode states and a parity helper for the PS/2 key display path.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        BRK
    } ps2_state_t;

    // Data bits plus parity bit must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit shift,
// frame validation and a partial-frame timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] idle_cnt;
    logic          frame_ok;

    assign fall = clk_prev & ~clk_sync[1];

    // shreg[0] is the start bit, [8:1] data, [9] parity; the stop bit is still on the pin.
    assign frame_ok = ~shreg[0] & data_sync[1] & odd_parity_ok(shreg[9:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            idle_cnt  <= '0;
            byte_vld  <= 1'b0;
            rx_byte   <= '0;
            err       <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            byte_vld  <= 1'b0;
            err       <= 1'b0;

            // An edge always wins over an expiring timeout in the same cycle.
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        byte_vld <= 1'b1;
                        rx_byte  <= shreg[8:1];
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    shreg   <= {data_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == '0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_display.sv
// Make/break decode of PS/2 scancodes with a distinct-press counter, mapped onto
// six hex digits (scancode on 1:0, count on 5:4, 3:2 blank).
module ps2_key_display
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [23:0] digit,
    output logic [5:0]  blank,
    output logic [5:0]  dot,
    output logic        frame_err
);

    logic       byte_vld;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_state_t state, state_n;
    logic [7:0] code, code_n;
    logic [7:0] count, count_n;
    logic       held_n;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .byte_vld (byte_vld),
        .rx_byte  (rx_byte),
        .err      (rx_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code      <= '0;
            count     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            count     <= count_n;
            frame_err <= frame_err | rx_err;
        end
    end

    // Extended-code prefixes never change state; only the base code is tracked.
    always_comb begin
        state_n = state;
        code_n  = code;
        count_n = count;
        if (byte_vld) begin
            case (state)
                IDLE: begin
                    if (rx_byte == PS2_BREAK) begin
                        state_n = BRK;
                    end else if (rx_byte != PS2_EXT) begin
                        code_n  = rx_byte;
                        count_n = count + 8'd1;
                        state_n = HELD;
                    end
                end
                HELD: begin
                    if (rx_byte == PS2_BREAK) begin
                        state_n = BRK;
                    end else if (rx_byte != PS2_EXT && rx_byte != code) begin
                        code_n  = rx_byte;
                        count_n = count + 8'd1;
                    end
                end
                BRK: begin
                    if (rx_byte != PS2_EXT) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign held_n = (state_n == HELD);

    // Display outputs are registered from next-state values so they move with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
            blank <= 6'b001111;
            dot   <= '0;
        end else begin
            digit <= {count_n, 8'h00, code_n};
            blank <= {2'b00, 2'b11, {2{~held_n}}};
            dot   <= {5'b00000, held_n};
        end
    end

endmodule

// File: tb/tb_ps2_key_display.sv
// Scoreboard bench for ps2_key_display: frames queue expected display states,
// a monitor compares them whenever the receiver reports a byte or a frame error.
module tb_ps2_key_display;

    localparam int TO   = 200;
    localparam int HALF = 2;
    localparam int GAP  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [23:0] digit;
    logic [5:0]  blank;
    logic [5:0]  dot;
    logic        frame_err;

    typedef struct {
        logic [7:0] code;
        logic [7:0] cnt;
        logic       held;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend   = 1'b0;

    ps2_key_display #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .digit     (digit),
        .blank     (blank),
        .dot       (dot),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Outputs update on the edge that consumes the event, so compare one cycle after seeing it.
    always @(negedge clk) begin
        if (pend) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got event expected none at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("digit",     32'(digit),     32'({e.cnt, 8'h00, e.code}));
                chk("blank",     32'(blank),     32'({4'b0011, {2{~e.held}}}));
                chk("dot",       32'(dot),       32'({5'b0, e.held}));
                chk("frame_err", 32'(frame_err), 32'(e.ferr));
            end
        end
        pend = !rst && (dut.byte_vld || dut.rx_err);
    end

    task automatic send_bit(input logic v);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b, input logic bad, input logic [7:0] code,
                       input logic [7:0] cnt, input logic held, input logic ferr);
        exp_t e;
        e.code = code; e.cnt = cnt; e.held = held; e.ferr = ferr;
        q.push_back(e);
        send_frame(b, bad);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_digit", 32'(digit),     32'h0);
        chk("rst_blank", 32'(blank),     32'h0F);
        chk("rst_dot",   32'(dot),       32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();

        // single keystroke
        key(8'h1C, 0, 8'h1C, 8'h01, 1, 0);
        key(8'hF0, 0, 8'h1C, 8'h01, 0, 0);
        key(8'h1C, 0, 8'h1C, 8'h01, 0, 0);

        // typematic repeat
        do_reset();
        for (int i = 0; i < 5; i++) key(8'h1C, 0, 8'h1C, 8'h01, 1, 0);
        key(8'hF0, 0, 8'h1C, 8'h01, 0, 0);
        key(8'h1C, 0, 8'h1C, 8'h01, 0, 0);

        // overlapping keys, extended prefix ignored in BRK
        do_reset();
        key(8'h1C, 0, 8'h1C, 8'h01, 1, 0);
        key(8'h32, 0, 8'h32, 8'h02, 1, 0);
        key(8'hE0, 0, 8'h32, 8'h02, 1, 0);
        key(8'hF0, 0, 8'h32, 8'h02, 0, 0);
        key(8'hE0, 0, 8'h32, 8'h02, 0, 0);
        key(8'h32, 0, 8'h32, 8'h02, 0, 0);

        // parity error then valid frame
        do_reset();
        key(8'h1C, 1, 8'h00, 8'h00, 0, 1);
        key(8'h1C, 0, 8'h1C, 8'h01, 1, 1);

        // timeout discards a partial frame
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (TO + 1) @(negedge clk);
        key(8'h1C, 0, 8'h1C, 8'h01, 1, 0);

        // 256 press/release pairs wrap the count
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            logic [7:0] n;
            c = (i % 2 == 0) ? 8'h1C : 8'h32;
            n = 8'((i + 1) % 256);
            key(c,     0, c, n, 1, 0);
            key(8'hF0, 0, c, n, 0, 0);
            key(c,     0, c, n, 0, 0);
        end

        // reset mid-frame: state cleared and the partial frame lost
        key(8'h45, 0, 8'h45, 8'h01, 1, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        do_reset();
        key(8'h1C, 0, 8'h1C, 8'h01, 1, 0);

        repeat (20) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_display.md
# ps2_key_display

Upstream feeder for the board's per-digit `hex2seg` decoders.
- Receives PS/2 keyboard frames, tracks make/break codes, and counts distinct key presses.
- Presents the current scancode and the 8-bit press count as hex nibbles, with a per-digit blank flag, for six `hex2seg` instances (digits 0–1 scancode, digits 4–5 count).
- Digits 2–3 are driven blank.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles without a PS/2 falling edge before a partial frame is discarded.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `digit`  out  24  six 4-bit nibbles. `[3:0]` = scancode low, `[7:4]` = scancode high, `[19:16]` = count low, `[23:20]` = count high. Remaining bits are 0.
- `blank`  out  6  1 = digit off. The top-level forces `seg` to `8'hFF` when set.
- `dot`  out  6  dot request per digit. Only `dot[0]` is used: it is 1 while a key is held.
- `frame_err`  out  1  sticky; set on a parity, start or stop error; cleared only by `rst`.

## Operation
- **Input conditioning:**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - A falling edge is the cycle where the synchronized `ps2_clk` is 0 and its previous value was 1.
- **Frame receive:**
  - Each frame is 11 bits, sampled on falling edges: start (0), d0..d7 LSB first, odd parity, stop (1).
  - The bit counter runs 0..10.
  - On bit 10:
    - If start=0, stop=1 and the parity of d0..d7 plus the parity bit is odd, emit a one-cycle `byte_vld` with `byte`.
    - Otherwise set `frame_err` and emit nothing.
  - The counter returns to 0 after bit 10 in either case.
- **Timeout:** when the bit counter is nonzero and `TIMEOUT_CYCLES` consecutive cycles pass with no falling edge, the counter clears to 0. `frame_err` is not set.
- **Decode FSM**, states `IDLE`, `HELD`, `BRK`:
  - `IDLE`:
    - byte `F0` → `BRK`.
    - byte `E0` → ignored.
    - any other byte → latch `code`, `count` += 1, go to `HELD`.
  - `HELD`:
    - byte `F0` → `BRK`.
    - byte `E0` → ignored.
    - byte == `code` → typematic repeat; no change.
    - byte ≠ `code` → latch the new `code`, `count` += 1, stay in `HELD`.
  - `BRK`:
    - next byte `E0` → ignored; stay in `BRK`.
    - any other byte → release: go to `IDLE`; `code` is retained.
- **Count:** 8-bit, wraps `FF` → `00`, no saturation.
- **Display mapping:**
  - `blank[1:0]` = 1 while in `IDLE` or `BRK`.
  - `blank[3:2]` = 1 always.
  - `blank[5:4]` = 0 always; the count is always shown, including 00.
  - `dot[0]` = 1 only in `HELD`; `dot[5:1]` = 0.

## Timing
- **Reset:** `rst` sampled high on a `clk` edge clears all state in that cycle:
  - synchronizers = 1s, bit counter = 0, timeout counter = 0, FSM = `IDLE`.
  - Outputs: `code` = 00, `count` = 00, `frame_err` = 0, `digit` = 0, `blank` = `6'b001111`, `dot` = 0.
  - A frame in flight when reset is applied is lost.
- **Input latency:** 2 cycles from a pin change to the synchronized value, plus 1 cycle for edge detect.
- **Byte latency:** `byte_vld` is asserted in the cycle after the 11th falling edge is detected.
- **Output latency:** FSM registers and the outputs update on the edge that consumes `byte_vld`. Total from the stop-bit edge detect to visible outputs is 2 cycles.
- All outputs are registered; there are no combinational paths from inputs.
- **Simultaneous events:** a falling edge in the same cycle the timeout expires counts as the edge; no timeout occurs.
- The timeout counter resets on every falling edge and is held at 0 while the bit counter is 0.

## Structure
- **Package `ps2_pkg`:**
  - constants `PS2_BREAK = 8'hF0` and `PS2_EXT = 8'hE0`.
  - state enum `ps2_state_t {IDLE, HELD, BRK}`.
  - `PS2_FRAME_BITS = 11`.
- **Sub-module `ps2_rx`:** synchronizer, edge detect, bit shifting, parity check and timeout.
  - Outputs `byte_vld`, `byte[7:0]` and `err`.
- **Top level:** the decode FSM, count and display mapping.

## Test plan
- **Single keystroke:** frames `1C`, `F0`, `1C`.
  - After `1C`: `digit[7:0]` = `1C`, `blank[1:0]` = 0, `dot[0]` = 1, count = 01.
  - After the break: `blank[1:0]` = `11`, `dot[0]` = 0, count stays 01.
- **Typematic repeat:** `1C` ×5, then `F0 1C` → count = 01.
- **Overlapping keys:** `1C`, `32`, `F0 32` → code = 32, count = 02, FSM = `IDLE` after the break.
- **Parity error:** a frame carrying `1C` with a flipped parity bit.
  - `frame_err` = 1; count = 00; `blank[1:0]` = `11`.
  - A following valid `1C` still decodes, and `frame_err` stays 1.
- **Timeout:** 5 bits, then an idle period of `TIMEOUT_CYCLES` + 1 cycles, then a full `1C` frame → decodes correctly, `frame_err` = 0.
- **Wrap and reset:** 256 press/release pairs alternating `1C` and `32` → count = 00.
  - `rst` asserted mid-frame → all outputs at their reset values on the next cycle.
